// File: rtl/spi_pkg.sv
// Definitions shared by both ends of the SPI configuration link.
// Frame length is shared with the receiver.
package spi_pkg;

  localparam int SPI_FRAME_BITS = 96;
  localparam int SPI_GAP_CYCLES = 4;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } spi_tx_state_t;

endpackage

// File: rtl/spi_frame_tx_if.sv
// Parallel frame handshake into the SPI transmitter.
// The master offers a frame; the slave accepts it with frame_ready.
interface spi_frame_tx_if
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = SPI_FRAME_BITS
);

  logic [FRAME_BITS-1:0] frame_data;
  logic                  frame_valid;
  logic                  frame_ready;

  modport master (
    output frame_data,
    output frame_valid,
    input  frame_ready
  );

  modport slave (
    input  frame_data,
    input  frame_valid,
    output frame_ready
  );

endinterface

// File: rtl/spi_frame_tx.sv
// Serialises one parallel configuration frame MSB-first on mosi, framed by active-low nss,
// with a minimum inter-frame gap. All outputs are registered.
module spi_frame_tx
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = SPI_FRAME_BITS,
  parameter int GAP_CYCLES = SPI_GAP_CYCLES,
  parameter int CNT_W      = $clog2(FRAME_BITS + GAP_CYCLES)
) (
  input  logic          clk,
  input  logic          rst_n,
  spi_frame_tx_if.slave frm,
  output logic          busy,
  output logic          done,
  output logic          nss,
  output logic          mosi
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_GAP = CNT_W'(GAP_CYCLES - 1);

  spi_tx_state_t         state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  nss_q, nss_d;
  logic                  mosi_q, mosi_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      nss_q   <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      nss_q   <= nss_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Accept uses the registered ready, so a frame offered on the GAP->IDLE edge waits one cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frm.frame_valid && ready_q) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_BIT) state_d = GAP;
      GAP:     if (cnt_q == LAST_GAP) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    nss_d   = 1'b1;
    mosi_d  = 1'b0;
    done_d  = 1'b0;
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
    case (state_q)
      IDLE: begin
        if (state_d == SHIFT) begin
          shift_d = frm.frame_data;
          cnt_d   = '0;
          nss_d   = 1'b0;
          mosi_d  = frm.frame_data[FRAME_BITS-1];
        end
      end
      SHIFT: begin
        if (state_d == GAP) begin
          shift_d = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          // The MSB is the bit on the wire now; the one below it goes out next.
          shift_d = shift_q << 1;
          cnt_d   = cnt_q + CNT_W'(1);
          nss_d   = 1'b0;
          mosi_d  = shift_q[FRAME_BITS-2];
        end
      end
      GAP: begin
        cnt_d = (state_d == IDLE) ? '0 : cnt_q + CNT_W'(1);
      end
      default: begin
      end
    endcase
  end

  assign frm.frame_ready = ready_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign nss             = nss_q;
  assign mosi            = mosi_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Scoreboard bench for spi_frame_tx: a default 96-bit instance with a serial monitor,
// plus a small 8-bit / gap-1 instance driven directly.
module tb_spi_frame_tx;
  import spi_pkg::*;

  localparam int FB_A  = 96;
  localparam int GAP_A = 4;
  localparam int FB_B  = 8;
  localparam int GAP_B = 1;

  typedef struct {
    logic [FB_A-1:0] data;
    int              fallCycle;
  } expT;

  logic clk;
  logic rst_n;
  logic busyA, doneA, nssA, mosiA;
  logic busyB, doneB, nssB, mosiB;

  int totalCnt = 0;
  int badCnt   = 0;
  int cycleCnt = 0;

  expT sbQ[$];
  int  fallLog[$];

  logic [FB_A-1:0] monCap;
  int              monBits;
  bit              monInFrame;
  bit              monPrevEnded;
  int              monFallCycle;
  int              monHighRun;
  expT             monExp;

  spi_frame_tx_if #(.FRAME_BITS(FB_A)) busA ();
  spi_frame_tx_if #(.FRAME_BITS(FB_B)) busB ();

  spi_frame_tx #(.FRAME_BITS(FB_A), .GAP_CYCLES(GAP_A)) dutA (
    .clk  (clk),
    .rst_n(rst_n),
    .frm  (busA.slave),
    .busy (busyA),
    .done (doneA),
    .nss  (nssA),
    .mosi (mosiA)
  );

  spi_frame_tx #(.FRAME_BITS(FB_B), .GAP_CYCLES(GAP_B)) dutB (
    .clk  (clk),
    .rst_n(rst_n),
    .frm  (busB.slave),
    .busy (busyB),
    .done (doneB),
    .nss  (nssB),
    .mosi (mosiB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    totalCnt++;
    if (observed !== expected) begin
      badCnt++;
      $display("[TB] FAIL %s: got %0h, wanted %0h (cycle %0d)", tag, observed, expected, cycleCnt);
    end
  endtask

  // Offers a frame at a negedge and waits (bounded) for the edge that takes it.
  task automatic applyStimulus(input logic [FB_A-1:0] data, input bit hold);
    int  budget;
    expT e;
    budget = 0;
    busA.frame_data  = data;
    busA.frame_valid = 1'b1;
    while (!busA.frame_ready && budget < 500) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("ready_timeout", 128'(budget < 500), 128'(1));
    if (budget < 500) begin
      e.data      = data;
      e.fallCycle = cycleCnt + 1;
      sbQ.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    if (!hold) busA.frame_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Serial monitor for instance A: rebuilds each frame from nss/mosi and pops the scoreboard.
  initial begin : monitorA
    monCap       = '0;
    monBits      = 0;
    monInFrame   = 1'b0;
    monPrevEnded = 1'b0;
    monHighRun   = 0;
    monFallCycle = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        monInFrame   = 1'b0;
        monPrevEnded = 1'b0;
        monBits      = 0;
        monHighRun   = 0;
        sbQ.delete();
      end else begin
        if (!nssA) begin
          if (!monInFrame) begin
            monInFrame   = 1'b1;
            monBits      = 0;
            monFallCycle = cycleCnt;
            fallLog.push_back(cycleCnt);
            if (monPrevEnded) checkOutput("gap_len_min", 128'(monHighRun >= GAP_A), 128'(1));
          end
          monCap = {monCap[FB_A-2:0], mosiA};
          monBits++;
          checkOutput("ready_in_frame", 128'(busA.frame_ready), 128'(0));
          checkOutput("busy_in_frame", 128'(busyA), 128'(1));
        end else begin
          checkOutput("mosi_idle", 128'(mosiA), 128'(0));
          if (monInFrame) begin
            monInFrame   = 1'b0;
            monPrevEnded = 1'b1;
            monHighRun   = 0;
            checkOutput("done_at_end", 128'(doneA), 128'(1));
            checkOutput("frame_present", 128'(sbQ.size() > 0), 128'(1));
            if (sbQ.size() > 0) begin
              monExp = sbQ.pop_front();
              checkOutput("frame_data", 128'(monCap), 128'(monExp.data));
              checkOutput("frame_len", 128'(monBits), 128'(FB_A));
              checkOutput("first_bit_cycle", 128'(monFallCycle), 128'(monExp.fallCycle));
            end
          end
          monHighRun++;
        end
        if (doneA) checkOutput("done_cycle", 128'(cycleCnt), 128'(monFallCycle + FB_A));
      end
    end
  end

  initial begin : mainSeq
    logic [FB_B-1:0] patB;
    logic [FB_B-1:0] capB;
    int              highB;
    rst_n            = 1'b0;
    busA.frame_data  = '0;
    busA.frame_valid = 1'b0;
    busB.frame_data  = '0;
    busB.frame_valid = 1'b0;

    waitCycles(3);
    checkOutput("rst_nss", 128'(nssA), 128'(1));
    checkOutput("rst_mosi", 128'(mosiA), 128'(0));
    checkOutput("rst_ready", 128'(busA.frame_ready), 128'(1));
    checkOutput("rst_busy", 128'(busyA), 128'(0));
    checkOutput("rst_done", 128'(doneA), 128'(0));
    rst_n = 1'b1;
    waitCycles(2);

    $display("[TB] single frame");
    applyStimulus(96'h123456789ABCDEF012345678, 1'b0);
    waitCycles(FB_A + GAP_A + 4);
    checkOutput("idle_ready", 128'(busA.frame_ready), 128'(1));
    checkOutput("idle_busy", 128'(busyA), 128'(0));

    $display("[TB] back-to-back frames");
    fallLog.delete();
    applyStimulus({FB_A{1'b1}}, 1'b1);
    applyStimulus('0, 1'b0);
    waitCycles(FB_A + GAP_A + 4);
    checkOutput("b2b_frames", 128'(fallLog.size()), 128'(2));
    if (fallLog.size() == 2)
      checkOutput("b2b_period", 128'(fallLog[1] - fallLog[0]), 128'(FB_A + GAP_A + 1));

    $display("[TB] valid ignored while busy");
    applyStimulus(96'hDEADBEEF_CAFEF00D_0123ABCD, 1'b0);
    for (int i = 0; i < FB_A + GAP_A - 1; i++) begin
      checkOutput("ready_while_busy", 128'(busA.frame_ready), 128'(0));
      busA.frame_data  = {12{8'hA5}};
      busA.frame_valid = (i % 5 == 0);
      @(negedge clk);
    end
    busA.frame_valid = 1'b0;
    waitCycles(FB_A + GAP_A + 4);
    checkOutput("no_extra_frame", 128'(sbQ.size()), 128'(0));

    $display("[TB] reset mid-frame");
    applyStimulus({FB_A{1'b1}}, 1'b0);
    waitCycles(40);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_nss", 128'(nssA), 128'(1));
    checkOutput("abort_mosi", 128'(mosiA), 128'(0));
    waitCycles(3);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_ready", 128'(busA.frame_ready), 128'(1));
    checkOutput("post_rst_busy", 128'(busyA), 128'(0));
    checkOutput("post_rst_nss", 128'(nssA), 128'(1));
    applyStimulus(96'h1, 1'b0);
    waitCycles(FB_A + GAP_A + 4);

    $display("[TB] 8-bit instance");
    patB = 8'h81;
    checkOutput("b_ready_idle", 128'(busB.frame_ready), 128'(1));
    busB.frame_data  = patB;
    busB.frame_valid = 1'b1;
    @(negedge clk);
    busB.frame_data = 8'h3C;
    for (int k = 0; k < FB_B; k++) begin
      checkOutput("b_nss_low", 128'(nssB), 128'(0));
      checkOutput("b_mosi_bit", 128'(mosiB), 128'(patB[FB_B-1-k]));
      @(negedge clk);
    end
    checkOutput("b_nss_end", 128'(nssB), 128'(1));
    checkOutput("b_done", 128'(doneB), 128'(1));
    highB = 0;
    while (nssB && highB < 20) begin
      highB++;
      @(negedge clk);
    end
    checkOutput("b_period", 128'(FB_B + highB), 128'(FB_B + GAP_B + 1));
    capB = '0;
    for (int k = 0; k < FB_B; k++) begin
      checkOutput("b_nss_low2", 128'(nssB), 128'(0));
      capB = {capB[FB_B-2:0], mosiB};
      if (k == 0) busB.frame_valid = 1'b0;
      @(negedge clk);
    end
    checkOutput("b_frame2", 128'(capB), 128'(8'h3C));
    checkOutput("b_done2", 128'(doneB), 128'(1));
    waitCycles(GAP_B + 3);
    checkOutput("b_idle_nss", 128'(nssB), 128'(1));
    checkOutput("b_idle_busy", 128'(busyB), 128'(0));

    checkOutput("sb_drained", 128'(sbQ.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule

// File: doc/spi_frame_tx.md
Name: spi_frame_tx

Overview:
- Transmit-side counterpart of the synth's `spi` configuration receiver.
- Accepts one parallel configuration frame (96 bits by default) through a valid/ready handshake and serialises it MSB-first on `mosi`, framed by active-low `nss`.
- One bit per `clk` cycle; the receiver samples `mosi` on the same `clk`.
- Used as the on-chip/FPGA-side config driver and as the stimulus model for receiver verification.

Parameters:
- FRAME_BITS, 96, number of bits per frame; must be ≥ 2.
- GAP_CYCLES, 4, minimum number of cycles `nss` stays high between frames; must be ≥ 1.
- CNT_W, $clog2(FRAME_BITS+GAP_CYCLES), width of the internal bit/gap counter; derived, do not override.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- frame_data  input  FRAME_BITS  frame to send; bit FRAME_BITS-1 is sent first.
- frame_valid  input  1  frame_data is valid.
- frame_ready  output  1  block can accept a frame.
- busy  output  1  frame in progress or inter-frame gap active.
- done  output  1  one-cycle pulse when the last bit has been sent.
- nss  output  1  active-low frame select to the receiver.
- mosi  output  1  serial data, MSB-first.

Behaviour:
- Reset (async assert, sync release):
  - nss=1, mosi=0, frame_ready=1, busy=0, done=0.
  - state=IDLE, shift register and counter cleared.
  - Asserting rst_n mid-frame forces nss high immediately (aborted frame) and discards the remaining bits.
- All outputs are registered; no combinational path from any input to any output.
- State machine (states: IDLE, SHIFT, GAP):
  - IDLE: frame_ready=1, nss=1.
    - On the edge where frame_valid & frame_ready: load the shift register with frame_data, set nss=0 and mosi=frame_data[FRAME_BITS-1], counter=0, go to SHIFT.
    - frame_ready drops on that same edge.
  - SHIFT: nss=0. Each edge: shift left by one, mosi=next bit, counter++.
    - nss stays low for exactly FRAME_BITS cycles; bit k (MSB=0) is on mosi during the k-th low cycle.
    - On the edge ending the last bit: nss=1, mosi=0, done=1 for one cycle, counter=0, go to GAP.
  - GAP: nss=1, frame_ready=0, busy=1. After GAP_CYCLES cycles, go to IDLE (frame_ready=1, busy=0).
- busy = (state != IDLE).
- Latency: the handshake edge is N; the first bit is visible in cycle N+1. done is visible in cycle N+FRAME_BITS+1.
- Minimum frame period is FRAME_BITS+GAP_CYCLES+1 cycles with continuous frame_valid.
- frame_valid while frame_ready=0 is ignored; frame_data changes during SHIFT do not affect the frame in flight.
- frame_valid and the handshake edge coinciding with GAP→IDLE: no accept that cycle; the frame is accepted on the next edge.
- mosi is 0 whenever nss=1.

Decomposition:
- Shared package `spi_pkg`:
  - SPI_FRAME_BITS = 96, shared with the receiver.
  - Enum spi_tx_state_t {IDLE, SHIFT, GAP}.
  - Default GAP constant.
- Single module, no sub-module; the shift register and counter are inline.

Test Plan:
- Single frame: send 96'h123456789ABCDEF012345678 → nss low for exactly 96 cycles starting the cycle after the handshake; the bench shift register captures 96'h123456789ABCDEF012345678; done pulses once, in cycle N+97.
- Loopback into `spi` receiver with the same frame → receiver's osc_count, filter_a/filter_b, adsr_* and mute match the field positions defined by the receiver's frame layout; trig pulses once.
- Back-to-back frames 96'hFFFF…F then 96'h0, with frame_valid held high → second nss fall occurs exactly 96+4+1 cycles after the first; nss stays high ≥4 cycles between frames; both frames are captured intact.
- frame_valid=1 with frame_data=96'hA5… pulsed during SHIFT and GAP → ignored: no extra frame, transmitted bits unchanged, frame_ready=0 throughout.
- rst_n low at bit 40 → nss=1 and mosi=0 asynchronously; after release, outputs are at reset values; a new frame 96'h1 sends cleanly (only the last bit high).
- FRAME_BITS=8, GAP_CYCLES=1, frame 8'h81 → nss low 8 cycles, mosi sequence 1,0,0,0,0,0,0,1; minimum period 10 cycles.
